// File: rtl/rr_mux_arb.sv
// Round-robin N:1 registered mux; accepted words appear on out_* the next cycle, one word per cycle sustained.
// Stalled output (out_ready=0 while full) drops every in_ready; RR_MUX_FORCE_SEL_EN adds a static-select override.
module rr_mux_arb #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
`endif
  output logic [SELW-1:0] out_sel
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            load_ok;
  logic            gnt_vld;
  logic            forced;
  logic            xfer;
  logic [SELW-1:0] gnt_idx;
  logic [W-1:0]    gnt_data;

  // Two passes: channels at or above ptr first, then the wrapped-around low channels.
  always_comb begin : arbitrate
    gnt_vld = 1'b0;
    gnt_idx = '0;
    forced  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld && in_valid[i] && (i >= int'(ptr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld && in_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(i);
      end
    end
`ifdef RR_MUX_FORCE_SEL_EN
    // Forced select out of range or not requesting leaves no grant at all.
    if (force_en) begin
      forced  = 1'b1;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
        if ((int'(force_sel) == i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end
`endif
  end

  always_comb begin : data_select
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  assign load_ok = (state_q == EMPTY) || out_ready;

  always_comb begin : ready_gen
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_ok && gnt_vld && !reset && (gnt_idx == SELW'(i));
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin : next_state
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      state_d    = FULL;
      out_data_d = gnt_data;
      out_sel_d  = gnt_idx;
      if (!forced) begin
        ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb (N=4, W=8) with a reference arbiter model and output scoreboard.
module tb_rr_mux_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_sel;
`ifdef RR_MUX_FORCE_SEL_EN
  logic         force_en;
  logic [1:0]   force_sel;
`endif

  always #5 clk = ~clk;

  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .out_sel   (out_sel)
  );

  localparam logic [N*W-1:0] BASE_DATA = {8'h43, 8'h32, 8'h21, 8'h10};

  int          checks = 0;
  int          errors = 0;
  int          m_ptr  = 0;
  bit          m_full = 1'b0;
  int          exp_gnt;
  logic [N-1:0] exp_ready;
  bit          exp_forced;
  bit          pushed;
  logic [9:0]  sb[$];
  logic [9:0]  exp_w;

  // Reference arbiter: scan from the model pointer with modulo wrap.
  task automatic predict();
    exp_gnt    = -1;
    exp_forced = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (exp_gnt < 0 && in_valid[c]) exp_gnt = c;
    end
`ifdef RR_MUX_FORCE_SEL_EN
    if (force_en) begin
      exp_forced = 1'b1;
      exp_gnt    = in_valid[force_sel] ? int'(force_sel) : -1;
    end
`endif
    exp_ready = '0;
    if (!reset && (!m_full || out_ready) && exp_gnt >= 0) exp_ready[exp_gnt] = 1'b1;
  endtask

  task automatic tick();
    pushed = 1'b0;
    @(posedge clk);
    if (reset) begin
      m_full = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else if (exp_ready != '0) begin
      sb.push_back({2'(exp_gnt), in_data[exp_gnt*W +: W]});
      pushed = 1'b1;
      m_full = 1'b1;
      if (!exp_forced) m_ptr = (exp_gnt + 1) % N;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = BASE_DATA;
    repeat (2) begin
      #1; predict();
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready got %b want 0000", in_ready);
      end
      tick();
    end
    reset = 1'b0;
    checks++;
    if ({out_valid, out_sel, out_data} !== 11'h000) begin
      errors++; $display("FAIL reset_out got v=%b sel=%0d d=%h want v=0 sel=0 d=00", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_single();
    in_valid = 4'b0100; in_data = BASE_DATA; in_data[23:16] = 8'hA5;
    #1; predict();
    checks++;
    if (in_ready !== 4'b0100 || in_ready !== exp_ready) begin
      errors++; $display("FAIL single_ready got %b want 0100", in_ready);
    end
    tick();
    if (pushed) begin
      exp_w = sb.pop_front();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, exp_w} || {out_sel, out_data} !== {2'd2, 8'hA5}) begin
        errors++; $display("FAIL single_out got v=%b sel=%0d d=%h want v=1 sel=2 d=a5", out_valid, out_sel, out_data);
      end
    end
    // ptr should now sit at 3, so ch3 wins with every channel requesting.
    in_valid = 4'hF; in_data = BASE_DATA;
    #1; predict();
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL single_ptr got %b want 1000", in_ready);
    end
    tick();
    if (pushed) begin
      exp_w = sb.pop_front();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, exp_w}) begin
        errors++; $display("FAIL single_ptr_out got sel=%0d d=%h want %h", out_sel, out_data, exp_w);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    in_valid = 4'hF; in_data = BASE_DATA; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1; predict();
      checks++;
      if (in_ready !== (4'b0001 << exp_seq[c]) || $countones(in_ready) != 1) begin
        errors++; $display("FAIL rr_ready cyc %0d got %b want %b", c, in_ready, 4'b0001 << exp_seq[c]);
      end
      tick();
      if (pushed) begin
        exp_w = sb.pop_front();
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, exp_w} || out_sel !== 2'(exp_seq[c]) ||
            out_data !== 8'(8'h10 + 8'h11 * exp_seq[c])) begin
          errors++; $display("FAIL rr_out cyc %0d got sel=%0d d=%h want sel=%0d", c, out_sel, out_data, exp_seq[c]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 4'hF;
    repeat (3) begin
      #1; predict();
      checks++;
      if (in_ready !== 4'b0000 || exp_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready got %b want 0000", in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 8'h21}) begin
        errors++; $display("FAIL bp_hold got v=%b sel=%0d d=%h want v=1 sel=1 d=21", out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1; in_valid = 4'b1000;
    #1; predict();
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release_ready got %b want 1000", in_ready);
    end
    tick();
    if (pushed) begin
      exp_w = sb.pop_front();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, exp_w} || {out_sel, out_data} !== {2'd3, 8'h43}) begin
        errors++; $display("FAIL bp_release_out got sel=%0d d=%h want sel=3 d=43", out_sel, out_data);
      end
    end
  endtask

  task automatic test_reset_midflight();
    in_valid = 4'hF; out_ready = 1'b1;
    #1; predict();
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_pre_ready got %b want 0001", in_ready);
    end
    tick();
    if (pushed) void'(sb.pop_front());
    out_ready = 1'b0; reset = 1'b1;
    #1; predict();
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_ready got %b want 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      errors++; $display("FAIL mid_reset_out got v=%b sel=%0d d=%h want v=0 sel=0 d=00", out_valid, out_sel, out_data);
    end
    reset = 1'b0; out_ready = 1'b1;
    #1; predict();
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_ptr_reset got %b want 0001", in_ready);
    end
    tick();
    if (pushed) begin
      exp_w = sb.pop_front();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, exp_w}) begin
        errors++; $display("FAIL mid_after_out got sel=%0d d=%h want %h", out_sel, out_data, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
      #1; predict();
      checks++;
      if (in_ready !== exp_ready || out_valid !== m_full) begin
        errors++; $display("FAIL b2b_ready cyc %0d got rdy=%b v=%b want rdy=%b v=%b", c, in_ready, out_valid, exp_ready, m_full);
      end
      tick();
      if (pushed) begin
        exp_w = sb.pop_front();
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, exp_w}) begin
          errors++; $display("FAIL b2b_out cyc %0d got v=%b sel=%0d d=%h want %h", c, out_valid, out_sel, out_data, exp_w);
        end
      end
    end
  endtask

`ifdef RR_MUX_FORCE_SEL_EN
  task automatic test_force();
    int saved;
    saved = m_ptr;
    in_valid = 4'hF; in_data = BASE_DATA; out_ready = 1'b1; force_en = 1'b1; force_sel = 2'd3;
    repeat (3) begin
      #1; predict();
      checks++;
      if (in_ready !== 4'b1000) begin
        errors++; $display("FAIL force_ready got %b want 1000", in_ready);
      end
      tick();
      if (pushed) begin
        exp_w = sb.pop_front();
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, exp_w} || out_sel !== 2'd3) begin
          errors++; $display("FAIL force_out got sel=%0d d=%h want sel=3", out_sel, out_data);
        end
      end
    end
    force_en = 1'b0;
    #1; predict();
    checks++;
    if (in_ready !== (4'b0001 << saved)) begin
      errors++; $display("FAIL force_resume got %b want %b", in_ready, 4'b0001 << saved);
    end
    tick();
    if (pushed) void'(sb.pop_front());
    force_en = 1'b1; in_valid = 4'b0111;
    #1; predict();
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL force_novalid got %b want 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL force_drain got v=%b want 0", out_valid);
    end
    force_en = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifdef RR_MUX_FORCE_SEL_EN
    force_en = 1'b0; force_sel = 2'd0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
`ifdef RR_MUX_FORCE_SEL_EN
    test_force();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
